// File: rtl/slv_guard_rst_ctrl.sv
// Reset controller that sequences a subordinate reset on behalf of a slave guard.
// Define SLV_GUARD_RST_CTRL_AUTO_EN to re-arm automatically after release instead of waiting for sw_clear_i.
module slv_guard_rst_ctrl #(
    parameter int HoldCycles    = 16,
    parameter int TimeoutCycles = 1024,
    parameter int RecovCntWidth = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     guard_ena_i,
    input  logic                     rst_req_i,
    input  logic                     rst_stat_i,
    input  logic                     sw_clear_i,
    output logic                     guard_ena_o,
    output logic                     sub_rst_no,
    output logic                     rst_clear_o,
    output logic                     busy_o,
    output logic                     fault_o,
    output logic [RecovCntWidth-1:0] recov_cnt_o
);

    localparam int MaxCycles = (HoldCycles > TimeoutCycles) ? HoldCycles : TimeoutCycles;
    localparam int TimerW    = $clog2(MaxCycles + 1);
    localparam logic [TimerW-1:0] HoldLast    = TimerW'(HoldCycles - 1);
    localparam logic [TimerW-1:0] TimeoutLast = TimerW'(TimeoutCycles - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ASSERT,
        S_HOLD,
        S_RELEASE,
        S_WAIT_SW,
        S_CLEAR,
        S_FAULT
    } state_e;

`ifdef SLV_GUARD_RST_CTRL_AUTO_EN
    localparam state_e ReleaseExit = S_CLEAR;
`else
    localparam state_e ReleaseExit = S_WAIT_SW;
`endif

    state_e                   r_state;
    state_e                   w_state_nxt;
    logic [TimerW-1:0]        r_timer;
    logic                     w_timer_inc;
    logic [RecovCntWidth-1:0] r_recov_cnt;

    // The timer restarts from zero whenever the state changes.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= S_IDLE;
            r_timer     <= '0;
            r_recov_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_state_nxt != r_state) begin
                r_timer <= '0;
            end else if (w_timer_inc) begin
                r_timer <= r_timer + TimerW'(1);
            end
            if (r_state == S_CLEAR && r_recov_cnt != '1) begin
                r_recov_cnt <= r_recov_cnt + RecovCntWidth'(1);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_timer_inc = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (rst_req_i) w_state_nxt = S_ASSERT;
            end
            S_ASSERT: begin
                if (rst_stat_i)                  w_state_nxt = S_HOLD;
                else if (r_timer == TimeoutLast) w_state_nxt = S_FAULT;
                else                             w_timer_inc = 1'b1;
            end
            S_HOLD: begin
                if (r_timer == HoldLast) w_state_nxt = S_RELEASE;
                else                     w_timer_inc = 1'b1;
            end
            S_RELEASE: begin
                if (!rst_stat_i)                 w_state_nxt = ReleaseExit;
                else if (r_timer == TimeoutLast) w_state_nxt = S_FAULT;
                else                             w_timer_inc = 1'b1;
            end
            S_WAIT_SW: begin
                if (sw_clear_i) w_state_nxt = S_CLEAR;
            end
            S_CLEAR: begin
                w_state_nxt = S_IDLE;
            end
            S_FAULT: begin
                if (sw_clear_i) w_state_nxt = S_RELEASE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        guard_ena_o = 1'b0;
        sub_rst_no  = 1'b1;
        rst_clear_o = 1'b0;
        busy_o      = 1'b1;
        fault_o     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                guard_ena_o = guard_ena_i;
                busy_o      = 1'b0;
            end
            S_ASSERT, S_HOLD: begin
                sub_rst_no = 1'b0;
            end
            S_RELEASE, S_WAIT_SW: begin
                sub_rst_no = 1'b1;
            end
            S_CLEAR: begin
                rst_clear_o = 1'b1;
            end
            S_FAULT: begin
                sub_rst_no = 1'b0;
                busy_o     = 1'b0;
                fault_o    = 1'b1;
            end
            default: begin
                busy_o = 1'b0;
            end
        endcase
    end

    assign recov_cnt_o = r_recov_cnt;

endmodule

// File: tb/tb_slv_guard_rst_ctrl.sv
// Directed bench for slv_guard_rst_ctrl with HoldCycles=4, TimeoutCycles=8, RecovCntWidth=2.
// Expectations follow the build selected by SLV_GUARD_RST_CTRL_AUTO_EN.
module tb_slv_guard_rst_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       guard_ena_i;
    logic       rst_req_i;
    logic       rst_stat_i;
    logic       sw_clear_i;
    logic       guard_ena_o;
    logic       sub_rst_no;
    logic       rst_clear_o;
    logic       busy_o;
    logic       fault_o;
    logic [1:0] recov_cnt_o;

    int total = 0;
    int bad   = 0;

    slv_guard_rst_ctrl #(
        .HoldCycles   (4),
        .TimeoutCycles(8),
        .RecovCntWidth(2)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .guard_ena_i(guard_ena_i),
        .rst_req_i  (rst_req_i),
        .rst_stat_i (rst_stat_i),
        .sw_clear_i (sw_clear_i),
        .guard_ena_o(guard_ena_o),
        .sub_rst_no (sub_rst_no),
        .rst_clear_o(rst_clear_o),
        .busy_o     (busy_o),
        .fault_o    (fault_o),
        .recov_cnt_o(recov_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset;
        rst_ni      = 1'b0;
        guard_ena_i = 1'b1;
        rst_req_i   = 1'b0;
        rst_stat_i  = 1'b0;
        sw_clear_i  = 1'b0;
        #1;
        total++; if (sub_rst_no !== 1'b1) begin bad++; $display("[TB] FAIL reset_srn: got %b want 1", sub_rst_no); end
        total++; if (rst_clear_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_clr: got %b want 0", rst_clear_o); end
        total++; if (busy_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b want 0", busy_o); end
        total++; if (fault_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_fault: got %b want 0", fault_o); end
        total++; if (recov_cnt_o !== 2'd0) begin bad++; $display("[TB] FAIL reset_cnt: got %0d want 0", recov_cnt_o); end
        total++; if (guard_ena_o !== 1'b1) begin bad++; $display("[TB] FAIL reset_gena_hi: got %b want 1", guard_ena_o); end
        guard_ena_i = 1'b0;
        #1;
        total++; if (guard_ena_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_gena_lo: got %b want 0", guard_ena_o); end
        guard_ena_i = 1'b1;
        tick;
        tick;
        rst_ni = 1'b1;
        tick;
        total++; if (busy_o !== 1'b0 || sub_rst_no !== 1'b1) begin bad++; $display("[TB] FAIL idle_after_reset: busy=%b srn=%b want 0/1", busy_o, sub_rst_no); end
    endtask

    task automatic test_recovery;
        int lowCnt = 0;
        int clrCnt = 0;
        rst_req_i  = 1'b1;
        rst_stat_i = 1'b0;
        for (int cyc = 1; cyc <= 29; cyc++) begin
            tick;
            if (sub_rst_no === 1'b0) lowCnt++;
            if (rst_clear_o === 1'b1) clrCnt++;
            if (cyc == 1) begin
                total++; if (guard_ena_o !== 1'b0 || busy_o !== 1'b1) begin bad++; $display("[TB] FAIL assert_entry: gena=%b busy=%b want 0/1", guard_ena_o, busy_o); end
            end
            if (cyc == 8) begin
                total++; if (sub_rst_no !== 1'b1 || busy_o !== 1'b1) begin bad++; $display("[TB] FAIL release_state: srn=%b busy=%b want 1/1", sub_rst_no, busy_o); end
            end
            rst_req_i  = 1'b0;
            rst_stat_i = (cyc >= 3 && cyc <= 8);
        end
        total++; if (lowCnt != 7) begin bad++; $display("[TB] FAIL srn_low_cycles: got %0d want 7", lowCnt); end
`ifdef SLV_GUARD_RST_CTRL_AUTO_EN
        total++; if (clrCnt != 1) begin bad++; $display("[TB] FAIL auto_clr_pulses: got %0d want 1", clrCnt); end
`else
        total++; if (clrCnt != 0) begin bad++; $display("[TB] FAIL wait_sw_clr_pulses: got %0d want 0", clrCnt); end
        total++; if (busy_o !== 1'b1 || sub_rst_no !== 1'b1) begin bad++; $display("[TB] FAIL wait_sw_state: busy=%b srn=%b want 1/1", busy_o, sub_rst_no); end
        sw_clear_i = 1'b1;
        tick;
        total++; if (rst_clear_o !== 1'b1) begin bad++; $display("[TB] FAIL sw_clear_pulse: got %b want 1", rst_clear_o); end
        sw_clear_i = 1'b0;
        tick;
`endif
        total++; if (rst_clear_o !== 1'b0) begin bad++; $display("[TB] FAIL clr_one_cycle: got %b want 0", rst_clear_o); end
        total++; if (recov_cnt_o !== 2'd1) begin bad++; $display("[TB] FAIL recov_cnt_1: got %0d want 1", recov_cnt_o); end
        total++; if (guard_ena_o !== 1'b1 || busy_o !== 1'b0) begin bad++; $display("[TB] FAIL gena_restored: gena=%b busy=%b want 1/0", guard_ena_o, busy_o); end
    endtask

    task automatic test_timeout;
        int n = 0;
        rst_req_i  = 1'b1;
        rst_stat_i = 1'b0;
        tick;
        total++; if (busy_o !== 1'b1 || sub_rst_no !== 1'b0) begin bad++; $display("[TB] FAIL timeout_assert: busy=%b srn=%b want 1/0", busy_o, sub_rst_no); end
        while (fault_o !== 1'b1 && n < 20) begin
            tick;
            n++;
        end
        total++; if (n != 8) begin bad++; $display("[TB] FAIL assert_to_fault: got %0d cycles want 8", n); end
        total++; if (sub_rst_no !== 1'b0 || busy_o !== 1'b0 || guard_ena_o !== 1'b0) begin bad++; $display("[TB] FAIL fault_outputs: srn=%b busy=%b gena=%b want 0/0/0", sub_rst_no, busy_o, guard_ena_o); end
        repeat (3) tick;
        total++; if (fault_o !== 1'b1) begin bad++; $display("[TB] FAIL fault_sticky: got %b want 1", fault_o); end
        sw_clear_i = 1'b1;
        rst_req_i  = 1'b0;
        tick;
        total++; if (fault_o !== 1'b0 || sub_rst_no !== 1'b1 || busy_o !== 1'b1) begin bad++; $display("[TB] FAIL fault_to_release: fault=%b srn=%b busy=%b want 0/1/1", fault_o, sub_rst_no, busy_o); end
`ifndef SLV_GUARD_RST_CTRL_AUTO_EN
        tick;
        total++; if (rst_clear_o !== 1'b0 || busy_o !== 1'b1) begin bad++; $display("[TB] FAIL fault_wait_sw: clr=%b busy=%b want 0/1", rst_clear_o, busy_o); end
`endif
        tick;
        total++; if (rst_clear_o !== 1'b1) begin bad++; $display("[TB] FAIL fault_clear: got %b want 1", rst_clear_o); end
        sw_clear_i = 1'b0;
        tick;
        total++; if (busy_o !== 1'b0 || recov_cnt_o !== 2'd2) begin bad++; $display("[TB] FAIL fault_idle: busy=%b cnt=%0d want 0/2", busy_o, recov_cnt_o); end
    endtask

    task automatic do_recovery;
        int  n = 0;
        logic seenClr = 1'b0;
        rst_req_i  = 1'b1;
        rst_stat_i = 1'b1;
        sw_clear_i = 1'b1;
        tick;
        rst_req_i = 1'b0;
        while (!seenClr && n < 40) begin
            tick;
            n++;
            if (sub_rst_no === 1'b1 && busy_o === 1'b1) rst_stat_i = 1'b0;
            if (rst_clear_o === 1'b1) seenClr = 1'b1;
        end
        total++; if (seenClr !== 1'b1) begin bad++; $display("[TB] FAIL recovery_timeout: clr seen=%b want 1", seenClr); end
        sw_clear_i = 1'b0;
        rst_stat_i = 1'b0;
        tick;
    endtask

    task automatic test_saturation;
        for (int k = 3; k <= 5; k++) begin
            do_recovery;
            total++; if (recov_cnt_o !== 2'd3) begin bad++; $display("[TB] FAIL recov_sat_%0d: got %0d want 3", k, recov_cnt_o); end
        end
    endtask

    task automatic test_reset_mid_hold;
        int clrCnt = 0;
        rst_req_i  = 1'b1;
        rst_stat_i = 1'b1;
        tick;
        rst_req_i = 1'b0;
        tick;
        tick;
        total++; if (sub_rst_no !== 1'b0 || busy_o !== 1'b1) begin bad++; $display("[TB] FAIL hold_before_reset: srn=%b busy=%b want 0/1", sub_rst_no, busy_o); end
        #3;
        rst_ni = 1'b0;
        #1;
        total++; if (sub_rst_no !== 1'b1 || busy_o !== 1'b0) begin bad++; $display("[TB] FAIL async_abort: srn=%b busy=%b want 1/0", sub_rst_no, busy_o); end
        total++; if (recov_cnt_o !== 2'd0 || guard_ena_o !== 1'b1) begin bad++; $display("[TB] FAIL async_abort_cnt: cnt=%0d gena=%b want 0/1", recov_cnt_o, guard_ena_o); end
        rst_stat_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            if (rst_clear_o === 1'b1) clrCnt++;
        end
        rst_ni = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick;
            if (rst_clear_o === 1'b1) clrCnt++;
        end
        total++; if (clrCnt != 0 || busy_o !== 1'b0) begin bad++; $display("[TB] FAIL abort_no_clear: pulses=%0d busy=%b want 0/0", clrCnt, busy_o); end
    endtask

    initial begin
        test_reset;
        test_recovery;
        test_timeout;
        test_saturation;
        test_reset_mid_hold;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
